tof_sweep_sequencer: RTL and testbench

//  Sequences the TOF delay-line/trigger datapath: steps the delay code over a programmed range,

---
 rtl/tof_seq_pkg.sv | 27 ++
 rtl/tof_edge_sync.sv | 22 ++
 rtl/tof_sweep_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_tof_sweep_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tof_seq_pkg.sv
// Shared types and default widths for the TOF sweep sequencer.
package tof_seq_pkg;

  localparam int unsigned DelayWDef    = 8;
  localparam int unsigned ShotWDef     = 16;
  localparam int unsigned LatWDef      = 7;
  localparam int unsigned SettleCycDef = 16;
  localparam int unsigned PulseCycDef  = 4;
  localparam int unsigned WinCycDef    = 64;
  localparam int unsigned GapCycDef    = 32;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StFire,
    StListen,
    StGap,
    StReport
  } state_e;

  typedef struct packed {
    logic [DelayWDef-1:0] code;
    logic [ShotWDef-1:0]  hits;
    logic [LatWDef-1:0]   min_lat;
  } result_t;

endpackage

// File: rtl/tof_edge_sync.sv
// Two-flop synchronizer for an asynchronous input followed by a rising-edge pulse.
module tof_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  // [0],[1] synchronize; [2] holds the previous synchronized value
  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/tof_sweep_sequencer.sv
// Steps the TOF delay code, fires trigger bursts per code and reports hit counts per point.
// Define TOF_SEQ_MINLAT_EN to track the per-point minimum hit latency.
module tof_sweep_sequencer
  import tof_seq_pkg::*;
#(
  parameter int unsigned DELAY_W    = DelayWDef,
  parameter int unsigned SHOT_W     = ShotWDef,
  parameter int unsigned SETTLE_CYC = SettleCycDef,
  parameter int unsigned PULSE_CYC  = PulseCycDef,
  parameter int unsigned WIN_CYC    = WinCycDef,
  parameter int unsigned GAP_CYC    = GapCycDef,
  parameter int unsigned LAT_W      = LatWDef
) (
  input  logic               io_mainClk,
  input  logic               io_asyncResetN,
  input  logic               io_cfg_start,
  input  logic               io_cfg_abort,
  input  logic [DELAY_W-1:0] io_cfg_codeStart,
  input  logic [DELAY_W-1:0] io_cfg_codeStop,
  input  logic [DELAY_W-1:0] io_cfg_codeStep,
  input  logic [SHOT_W-1:0]  io_cfg_shots,
  output logic               io_busy,
  output logic               io_done,
  output logic [DELAY_W-1:0] io_delay,
  output logic               io_trigOut,
  input  logic               io_hitIn,
  output logic               io_result_valid,
  input  logic               io_result_ready,
  output logic [DELAY_W-1:0] io_result_code,
  output logic [SHOT_W-1:0]  io_result_hits,
  output logic [LAT_W-1:0]   io_result_minLat
);

  localparam int unsigned MaxCyc =
      (SETTLE_CYC > WIN_CYC) ? ((SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC)
                             : ((WIN_CYC > GAP_CYC) ? WIN_CYC : GAP_CYC);
  localparam int unsigned CntW = $clog2(MaxCyc + 1);

  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYC - 1);
  localparam logic [CntW-1:0] PulseLast  = CntW'(PULSE_CYC - 1);
  localparam logic [CntW-1:0] WinLast    = CntW'(WIN_CYC - 1);
  localparam logic [CntW-1:0] GapLast    = CntW'(GAP_CYC - 1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DELAY_W-1:0]  code_q, code_d;
  logic [DELAY_W-1:0]  stop_q, stop_d;
  logic [DELAY_W-1:0]  step_q, step_d;
  logic [SHOT_W-1:0]   shots_cfg_q, shots_cfg_d;
  logic [SHOT_W-1:0]   shots_left_q, shots_left_d;
  logic [SHOT_W-1:0]   hits_q, hits_d;
  logic                hit_seen_q, hit_seen_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                trig_q, trig_d;
  logic                valid_q, valid_d;

  logic                hit_rise;
  logic                in_win;
  logic                count_hit;
  logic                clear_rec;
  logic                last_point;
  logic [DELAY_W:0]    code_sum;

  tof_edge_sync u_hit_sync (
    .clk_i  (io_mainClk),
    .rst_ni (io_asyncResetN),
    .d_i    (io_hitIn),
    .rise_o (hit_rise)
  );

  // The window spans FIRE and LISTEN; cnt_q keeps counting across both so it is the latency.
  assign in_win    = (state_q == StFire) || (state_q == StListen);
  assign count_hit = in_win && hit_rise && !hit_seen_q;

  // Extra carry bit catches codes that would wrap past the top of the range.
  assign code_sum   = {1'b0, code_q} + {1'b0, step_q};
  assign last_point = code_sum[DELAY_W] || (code_sum[DELAY_W-1:0] > stop_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    stop_d       = stop_q;
    step_d       = step_q;
    shots_cfg_d  = shots_cfg_q;
    shots_left_d = shots_left_q;
    hits_d       = hits_q;
    hit_seen_d   = hit_seen_q;
    done_d       = 1'b0;
    clear_rec    = 1'b0;

    case (state_q)
      StIdle: begin
        if (io_cfg_start && !io_cfg_abort) begin
          code_d       = io_cfg_codeStart;
          stop_d       = io_cfg_codeStop;
          step_d       = (io_cfg_codeStep == '0) ? DELAY_W'(1) : io_cfg_codeStep;
          shots_cfg_d  = (io_cfg_shots == '0) ? SHOT_W'(1) : io_cfg_shots;
          shots_left_d = (io_cfg_shots == '0) ? SHOT_W'(1) : io_cfg_shots;
          hits_d       = '0;
          clear_rec    = 1'b1;
          cnt_d        = '0;
          state_d      = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          cnt_d      = '0;
          hit_seen_d = 1'b0;
          state_d    = StFire;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFire: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == PulseLast) begin
          if (WIN_CYC == PULSE_CYC) begin
            cnt_d   = '0;
            state_d = StGap;
          end else begin
            state_d = StListen;
          end
        end
      end
      StListen: begin
        if (cnt_q == WinLast) begin
          cnt_d   = '0;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d = '0;
          if (shots_left_q > SHOT_W'(1)) begin
            shots_left_d = shots_left_q - 1'b1;
            hit_seen_d   = 1'b0;
            state_d      = StFire;
          end else begin
            state_d = StReport;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReport: begin
        if (io_result_ready) begin
          hits_d    = '0;
          clear_rec = 1'b1;
          cnt_d     = '0;
          if (last_point) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            code_d       = code_sum[DELAY_W-1:0];
            shots_left_d = shots_cfg_q;
            state_d      = StSettle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (count_hit) begin
      hits_d     = hits_q + 1'b1;
      hit_seen_d = 1'b1;
    end

    if (io_cfg_abort && (state_q != StIdle)) begin
      state_d    = StIdle;
      cnt_d      = '0;
      hits_d     = '0;
      hit_seen_d = 1'b0;
      done_d     = 1'b0;
      clear_rec  = 1'b1;
    end

    busy_d  = (state_d != StIdle);
    trig_d  = (state_d == StFire);
    valid_d = (state_d == StReport);
  end

  always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
    if (!io_asyncResetN) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      code_q       <= '0;
      stop_q       <= '0;
      step_q       <= '0;
      shots_cfg_q  <= '0;
      shots_left_q <= '0;
      hits_q       <= '0;
      hit_seen_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      trig_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      stop_q       <= stop_d;
      step_q       <= step_d;
      shots_cfg_q  <= shots_cfg_d;
      shots_left_q <= shots_left_d;
      hits_q       <= hits_d;
      hit_seen_q   <= hit_seen_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      trig_q       <= trig_d;
      valid_q      <= valid_d;
    end
  end

`ifdef TOF_SEQ_MINLAT_EN
  logic [LAT_W-1:0] minlat_q, minlat_d;
  logic [LAT_W-1:0] win_lat;

  assign win_lat = LAT_W'(cnt_q);

  always_comb begin
    minlat_d = minlat_q;
    if (clear_rec) begin
      minlat_d = '1;
    end else if (count_hit && (win_lat < minlat_q)) begin
      minlat_d = win_lat;
    end
  end

  always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
    if (!io_asyncResetN) begin
      minlat_q <= '0;
    end else begin
      minlat_q <= minlat_d;
    end
  end

  assign io_result_minLat = minlat_q;
`else
  assign io_result_minLat = '1;
`endif

  assign io_busy         = busy_q;
  assign io_done         = done_q;
  assign io_delay        = code_q;
  assign io_trigOut      = trig_q;
  assign io_result_valid = valid_q;
  assign io_result_code  = code_q;
  assign io_result_hits  = hits_q;

endmodule

// File: tb/tb_tof_sweep_sequencer.sv
// Directed bench for tof_sweep_sequencer; expected minLat follows TOF_SEQ_MINLAT_EN.
module tb_tof_sweep_sequencer;

`ifdef TOF_SEQ_MINLAT_EN
  localparam int unsigned LatOn = 1;
`else
  localparam int unsigned LatOn = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_cfg_start, io_cfg_abort;
  logic [7:0]  io_cfg_codeStart, io_cfg_codeStop, io_cfg_codeStep;
  logic [15:0] io_cfg_shots;
  logic        io_busy, io_done, io_trigOut, io_hitIn;
  logic [7:0]  io_delay, io_result_code;
  logic        io_result_valid, io_result_ready;
  logic [15:0] io_result_hits;
  logic [6:0]  io_result_minLat;

  int checks = 0;
  int errors = 0;
  int rises = 0;
  int high_cyc = 0;
  int dones = 0;
  logic prev_trig = 1'b0;

  tof_sweep_sequencer dut (
    .io_mainClk       (clk),
    .io_asyncResetN   (rst_n),
    .io_cfg_start     (io_cfg_start),
    .io_cfg_abort     (io_cfg_abort),
    .io_cfg_codeStart (io_cfg_codeStart),
    .io_cfg_codeStop  (io_cfg_codeStop),
    .io_cfg_codeStep  (io_cfg_codeStep),
    .io_cfg_shots     (io_cfg_shots),
    .io_busy          (io_busy),
    .io_done          (io_done),
    .io_delay         (io_delay),
    .io_trigOut       (io_trigOut),
    .io_hitIn         (io_hitIn),
    .io_result_valid  (io_result_valid),
    .io_result_ready  (io_result_ready),
    .io_result_code   (io_result_code),
    .io_result_hits   (io_result_hits),
    .io_result_minLat (io_result_minLat)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (io_trigOut && !prev_trig) rises <= rises + 1;
    if (io_trigOut) high_cyc <= high_cyc + 1;
    if (io_done) dones <= dones + 1;
    prev_trig <= io_trigOut;
  end

  function automatic int unsigned exp_lat(input int unsigned l);
    return (LatOn != 0) ? l : 127;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_trig(input string tag);
    int n = 0;
    while (io_trigOut !== 1'b1 && n < 400) begin
      step(1);
      n++;
    end
    check({tag, " trig_wait"}, 32'(io_trigOut === 1'b1), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (io_result_valid !== 1'b1 && n < 600) begin
      step(1);
      n++;
    end
    check({tag, " valid_wait"}, 32'(io_result_valid === 1'b1), 32'd1);
  endtask

  // Hit raised in window cycle (lat-2); the two sync flops add the remaining two cycles.
  task automatic hit_shot(input int lat);
    step(lat - 2);
    io_hitIn = 1'b1;
    step(4);
    io_hitIn = 1'b0;
  endtask

  task automatic start_sweep(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s,
                             input logic [15:0] n);
    io_cfg_codeStart = a;
    io_cfg_codeStop  = b;
    io_cfg_codeStep  = s;
    io_cfg_shots     = n;
    io_cfg_start     = 1'b1;
    step(1);
    io_cfg_start     = 1'b0;
    io_cfg_codeStart = 8'd99;
    io_cfg_codeStop  = 8'd1;
    io_cfg_codeStep  = 8'd7;
    io_cfg_shots     = 16'd9;
  endtask

  task automatic take_record;
    io_result_ready = 1'b1;
    step(1);
    io_result_ready = 1'b0;
  endtask

  initial begin
    int base_rises, base_high, base_done;
    logic trig_seen;

    rst_n = 1'b0;
    io_cfg_start = 1'b0;
    io_cfg_abort = 1'b0;
    io_cfg_codeStart = '0;
    io_cfg_codeStop = '0;
    io_cfg_codeStep = '0;
    io_cfg_shots = '0;
    io_hitIn = 1'b0;
    io_result_ready = 1'b0;
    step(3);
    check("rst busy", 32'(io_busy), 0);
    check("rst done", 32'(io_done), 0);
    check("rst delay", 32'(io_delay), 0);
    check("rst trig", 32'(io_trigOut), 0);
    check("rst valid", 32'(io_result_valid), 0);
    check("rst hits", 32'(io_result_hits), 0);
    check("rst minlat", 32'(io_result_minLat), (LatOn != 0) ? 0 : 127);
    rst_n = 1'b1;
    step(2);

    // Reset asserted mid-FIRE
    start_sweep(8'd3, 8'd9, 8'd3, 16'd2);
    check("start busy", 32'(io_busy), 1);
    check("start delay", 32'(io_delay), 3);
    wait_trig("midfire");
    rst_n = 1'b0;
    #1;
    check("midfire trig", 32'(io_trigOut), 0);
    check("midfire busy", 32'(io_busy), 0);
    check("midfire delay", 32'(io_delay), 0);
    check("midfire valid", 32'(io_result_valid), 0);
    step(2);
    rst_n = 1'b1;
    step(3);
    check("post-rst busy", 32'(io_busy), 0);
    check("post-rst trig", 32'(io_trigOut), 0);

    // Sweep 2..6 step 2, 3 shots, hit latency 10 on every shot
    base_rises = rises;
    base_high = high_cyc;
    base_done = dones;
    start_sweep(8'd2, 8'd6, 8'd2, 16'd3);
    check("sweep busy", 32'(io_busy), 1);
    check("sweep delay0", 32'(io_delay), 2);
    for (int p = 0; p < 3; p++) begin
      for (int s = 0; s < 3; s++) begin
        wait_trig("sweep");
        hit_shot(10);
      end
      wait_valid("sweep");
      check("sweep code", 32'(io_result_code), 32'(2 + 2 * p));
      check("sweep hits", 32'(io_result_hits), 3);
      check("sweep minlat", 32'(io_result_minLat), exp_lat(10));
      take_record();
      if (p < 2) begin
        check("sweep valid drop", 32'(io_result_valid), 0);
        check("sweep next delay", 32'(io_delay), 32'(4 + 2 * p));
        check("sweep hits clr", 32'(io_result_hits), 0);
      end else begin
        check("sweep done", 32'(io_done), 1);
        check("sweep idle busy", 32'(io_busy), 0);
        check("sweep final delay", 32'(io_delay), 6);
        step(1);
        check("sweep done pulse", 32'(io_done), 0);
      end
    end
    check("sweep trig pulses", 32'(rises - base_rises), 9);
    check("sweep trig cycles", 32'(high_cyc - base_high), 36);
    check("sweep done count", 32'(dones - base_done), 1);

    // Wrap guard with backpressure on the first record
    start_sweep(8'd250, 8'd255, 8'd4, 16'd1);
    wait_valid("wrap");
    check("wrap code0", 32'(io_result_code), 250);
    check("wrap hits0", 32'(io_result_hits), 0);
    check("wrap minlat0", 32'(io_result_minLat), 127);
    base_rises = rises;
    trig_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (io_trigOut) trig_seen = 1'b1;
    end
    check("bp valid held", 32'(io_result_valid), 1);
    check("bp code held", 32'(io_result_code), 250);
    check("bp trig low", 32'(trig_seen), 0);
    check("bp no shots", 32'(rises - base_rises), 0);
    take_record();
    wait_valid("wrap");
    check("wrap code1", 32'(io_result_code), 254);
    take_record();
    check("wrap done", 32'(io_done), 1);
    check("wrap busy", 32'(io_busy), 0);
    check("wrap delay", 32'(io_delay), 254);

    // Two edges in one window plus one in the gap count as a single hit
    start_sweep(8'd5, 8'd5, 8'd1, 16'd2);
    wait_trig("glitch");
    step(5);  io_hitIn = 1'b1;
    step(4);  io_hitIn = 1'b0;
    step(8);  io_hitIn = 1'b1;
    step(4);  io_hitIn = 1'b0;
    step(54); io_hitIn = 1'b1;
    step(5);  io_hitIn = 1'b0;
    wait_trig("glitch shot2");
    wait_valid("glitch");
    check("glitch code", 32'(io_result_code), 5);
    check("glitch hits", 32'(io_result_hits), 1);
    check("glitch minlat", 32'(io_result_minLat), exp_lat(7));
    take_record();
    check("glitch done", 32'(io_done), 1);

    // Abort during LISTEN of the second point
    start_sweep(8'd10, 8'd30, 8'd10, 16'd1);
    wait_trig("abort p1");
    hit_shot(10);
    wait_valid("abort p1");
    check("abort p1 code", 32'(io_result_code), 10);
    check("abort p1 hits", 32'(io_result_hits), 1);
    take_record();
    wait_trig("abort p2");
    step(10);
    base_done = dones;
    io_cfg_abort = 1'b1;
    step(1);
    io_cfg_abort = 1'b0;
    check("abort busy", 32'(io_busy), 0);
    check("abort valid", 32'(io_result_valid), 0);
    check("abort trig", 32'(io_trigOut), 0);
    check("abort done", 32'(io_done), 0);
    step(150);
    check("abort no done", 32'(dones - base_done), 0);
    check("abort stays idle", 32'(io_busy), 0);

    io_cfg_start = 1'b1;
    io_cfg_abort = 1'b1;
    step(1);
    io_cfg_start = 1'b0;
    io_cfg_abort = 1'b0;
    check("start+abort idle", 32'(io_busy), 0);

    // Restart after abort; zero step and zero shots behave as 1
    base_rises = rises;
    start_sweep(8'd7, 8'd7, 8'd0, 16'd0);
    check("restart delay", 32'(io_delay), 7);
    wait_trig("restart");
    hit_shot(10);
    wait_valid("restart");
    check("restart code", 32'(io_result_code), 7);
    check("restart hits", 32'(io_result_hits), 1);
    check("restart minlat", 32'(io_result_minLat), exp_lat(10));
    take_record();
    check("restart done", 32'(io_done), 1);
    check("restart shots", 32'(rises - base_rises), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
